// File: rtl/chime_pkg.sv
// Shared types and constants for the doorbell chime sequencer.
// Optional feature macro used by the sequencer: CHIME_RETRIGGER_EN.
package chime_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TONE_A = 2'd1,
    TONE_B = 2'd2,
    DONE   = 2'd3
  } chime_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/chime_edge_detect.sv
// Rising-edge detector for the debounced doorbell button.
// The history register resets to RESET_VAL so a held button is not seen as a press.
module chime_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_press
);

  logic r_button_q;

  // Button history for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_button_q <= RESET_VAL;
    end else begin
      r_button_q <= i_button;
    end
  end

  assign o_press = i_button & ~r_button_q;

endmodule

// File: rtl/chime_sequencer.sv
// Doorbell chime sequencer: plays A then B phases REPEATS times, then pulses done.
// Define CHIME_RETRIGGER_EN to let a press while busy restart the chime.
module chime_sequencer
  import chime_pkg::*;
#(
  parameter int HOLD_A  = 5,
  parameter int HOLD_B  = 5,
  parameter int REPEATS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic sel,
  output logic busy,
  output logic done
);

  localparam int PW = $clog2(max2(HOLD_A, HOLD_B) + 1);
  localparam int RW = $clog2(REPEATS + 1);
  localparam logic [PW-1:0] A_LAST = PW'(HOLD_A - 1);
  localparam logic [PW-1:0] B_LAST = PW'(HOLD_B - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEATS - 1);

  chime_state_t  r_state;
  logic [PW-1:0] r_phase_cnt;
  logic [RW-1:0] r_rep_cnt;
  logic          r_sel;
  logic          r_busy;
  logic          r_done;
  logic          w_press;
  logic          w_restart;

  chime_edge_detect #(
    .RESET_VAL (1'b1)
  ) u_edge (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_button (button),
    .o_press  (w_press)
  );

`ifdef CHIME_RETRIGGER_EN
  assign w_restart = w_press & ((r_state == TONE_A) | (r_state == TONE_B));
`else
  assign w_restart = 1'b0;
`endif

  // Chime FSM; outputs are registered alongside the state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase_cnt <= '0;
      r_rep_cnt   <= '0;
      r_sel       <= SEL_A;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_restart) begin
      r_state     <= TONE_A;
      r_phase_cnt <= '0;
      r_rep_cnt   <= '0;
      r_sel       <= SEL_A;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_phase_cnt <= '0;
          r_rep_cnt   <= '0;
          r_done      <= 1'b0;
          r_sel       <= SEL_A;
          if (w_press) begin
            r_state <= TONE_A;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        TONE_A: begin
          r_busy <= 1'b1;
          r_done <= 1'b0;
          if (r_phase_cnt == A_LAST) begin
            r_state     <= TONE_B;
            r_phase_cnt <= '0;
            r_sel       <= SEL_B;
          end else begin
            r_state     <= TONE_A;
            r_phase_cnt <= r_phase_cnt + PW'(1);
            r_sel       <= SEL_A;
          end
        end
        TONE_B: begin
          if (r_phase_cnt == B_LAST) begin
            r_phase_cnt <= '0;
            r_sel       <= SEL_A;
            if (r_rep_cnt == R_LAST) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state   <= TONE_A;
              r_rep_cnt <= r_rep_cnt + RW'(1);
              r_busy    <= 1'b1;
              r_done    <= 1'b0;
            end
          end else begin
            r_state     <= TONE_B;
            r_phase_cnt <= r_phase_cnt + PW'(1);
            r_sel       <= SEL_B;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        DONE: begin
          // Presses landing here are deliberately dropped
          r_state     <= IDLE;
          r_phase_cnt <= '0;
          r_rep_cnt   <= '0;
          r_sel       <= SEL_A;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_phase_cnt <= '0;
          r_rep_cnt   <= '0;
          r_sel       <= SEL_A;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = r_sel;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_chime_sequencer.sv
// Scoreboard bench for chime_sequencer: default instance plus a 1/1/1 instance.
// Expected {sel,busy,done} per cycle is queued by stimulus and checked by a monitor.
module tb_chime_sequencer;

  logic clk;
  logic rst;
  logic button;
  logic button_s;
  logic sel, busy, done;
  logic sel_s, busy_s, done_s;

  int vectors;
  int miscompares;

  typedef struct {
    bit         chk_m;
    logic [2:0] m;
    bit         chk_s;
    logic [2:0] s;
    int         tag;
  } exp_t;

  exp_t q[$];

  chime_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .sel    (sel),
    .busy   (busy),
    .done   (done)
  );

  chime_sequencer #(
    .HOLD_A  (1),
    .HOLD_B  (1),
    .REPEATS (1)
  ) dut_s (
    .clk    (clk),
    .rst    (rst),
    .button (button_s),
    .sel    (sel_s),
    .busy   (busy_s),
    .done   (done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {sel,busy,done} k cycles after the starting edge of a default chime
  function automatic logic [2:0] chime_exp(input int k);
    logic [2:0] r;
    if (k < 0) begin
      r = 3'b000;
    end else if (k < 20) begin
      r = {((k % 10) >= 5) ? 1'b1 : 1'b0, 1'b1, 1'b0};
    end else if (k == 20) begin
      r = 3'b001;
    end else begin
      r = 3'b000;
    end
    return r;
  endfunction

  task automatic tick(input logic r, input logic b, input logic bs,
                      input bit cm, input logic [2:0] em,
                      input bit cs, input logic [2:0] es, input int tag);
    exp_t e;
    @(negedge clk);
    rst      = r;
    button   = b;
    button_s = bs;
    e.chk_m  = cm;
    e.m      = em;
    e.chk_s  = cs;
    e.s      = es;
    e.tag    = tag;
    q.push_back(e);
  endtask

  // Monitor: sample just after each rising edge and compare against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_m) begin
          vectors++;
          if ({sel, busy, done} !== e.m) begin
            miscompares++;
            $display("FAIL test%0d main @%0t: got sel/busy/done=%b required %b",
                     e.tag, $time, {sel, busy, done}, e.m);
          end
        end
        if (e.chk_s) begin
          vectors++;
          if ({sel_s, busy_s, done_s} !== e.s) begin
            miscompares++;
            $display("FAIL test%0d small @%0t: got sel/busy/done=%b required %b",
                     e.tag, $time, {sel_s, busy_s, done_s}, e.s);
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] small_exp [4];
    logic [2:0] e5;
    logic [2:0] e6;
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    button   = 1'b1;
    button_s = 1'b0;
    small_exp[0] = 3'b010;
    small_exp[1] = 3'b110;
    small_exp[2] = 3'b001;
    small_exp[3] = 3'b000;

    // 1: button held high through and after reset never starts a chime
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 1);

    // 2: single default chime
    tick(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 2);
    for (int k = 0; k <= 21; k++)
      tick(1'b0, (k == 0), 1'b0, 1'b1, chime_exp(k), 1'b1, 3'b000, 2);

    // 3: minimal configuration on the second instance
    for (int k = 0; k < 4; k++)
      tick(1'b0, 1'b0, (k == 0), 1'b1, 3'b000, 1'b1, small_exp[k], 3);

    // 4: reset at E0+7 aborts without a done pulse
    for (int k = 0; k <= 6; k++)
      tick(1'b0, (k == 0), 1'b0, 1'b1, chime_exp(k), 1'b1, 3'b000, 4);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 4);
    for (int i = 0; i < 25; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 3'b000, 4);

    // 5: second press at E0+12
    for (int k = 0; k <= 34; k++) begin
`ifdef CHIME_RETRIGGER_EN
      e5 = (k < 12) ? chime_exp(k) : chime_exp(k - 12);
`else
      e5 = chime_exp(k);
`endif
      tick(1'b0, (k == 0) || (k == 12), 1'b0, 1'b1, e5, 1'b1, 3'b000, 5);
    end

    // 6: press on the DONE cycle is dropped, a later press starts normally
    for (int k = 0; k <= 44; k++) begin
      e6 = (k <= 22) ? chime_exp(k) : chime_exp(k - 23);
      tick(1'b0, (k == 0) || (k == 21) || (k == 23), 1'b0, 1'b1, e6, 1'b1, 3'b000, 6);
    end

    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 0);
    @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
